// File: rtl/piso_shifter_pkg.sv
// piso_shifter_pkg: shared state type for the serialiser
package piso_shifter_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
endpackage

// File: rtl/piso_shifter.sv
// piso_shifter: valid/ready parallel-in, enable-paced serial-out shift register
module piso_shifter
  import piso_shifter_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  s_rst_n_i,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic                  q_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int CW = $clog2(DATA_WIDTH);
  state_t                state;
  logic [DATA_WIDTH-1:0] sr;
  logic [DATA_WIDTH-1:0] nxt;
  logic [CW-1:0]         cnt;
  logic                  nbit;
  logic                  first;
  logic                  last;
  always_comb begin
    nxt   = MSB_FIRST ? sr << 1 : sr >> 1;
    nbit  = MSB_FIRST ? sr[DATA_WIDTH-2] : sr[1];
    first = MSB_FIRST ? s_data_i[DATA_WIDTH-1] : s_data_i[0];
    last  = cnt == CW'(DATA_WIDTH - 1);
  end
  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      q_o    <= IDLE_LEVEL;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (state == IDLE) begin
        if (s_valid_i) begin
          state <= SHIFT;
          sr    <= s_data_i;
          cnt   <= '0;
          q_o   <= first;
        end
      end else if (enable_i) begin
        if (last) begin
          state  <= IDLE;
          q_o    <= IDLE_LEVEL;
          done_o <= 1'b1;
        end else begin
          sr  <= nxt;
          q_o <= nbit;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
  assign s_ready_o = state == IDLE;
  assign busy_o    = state == SHIFT;
endmodule

// File: tb/tb_piso_shifter.sv
// tb_piso_shifter: directed checks on MSB-first, LSB-first and 2-bit configurations
module tb_piso_shifter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_a = 1'b0, valid_a = 1'b0, ready_a, q_a, busy_a, done_a;
  logic [7:0] data_a = '0;
  logic       en_b = 1'b0, valid_b = 1'b0, ready_b, q_b, busy_b, done_b;
  logic [7:0] data_b = '0;
  logic       en_c = 1'b0, valid_c = 1'b0, ready_c, q_c, busy_c, done_c;
  logic [1:0] data_c = '0;
  int         tests = 0;
  int         fails = 0;
  always #5 clk = ~clk;
  piso_shifter #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk_i(clk), .s_rst_n_i(rst_n), .enable_i(en_a), .s_data_i(data_a), .s_valid_i(valid_a),
    .s_ready_o(ready_a), .q_o(q_a), .busy_o(busy_a), .done_o(done_a));
  piso_shifter #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
    .clk_i(clk), .s_rst_n_i(rst_n), .enable_i(en_b), .s_data_i(data_b), .s_valid_i(valid_b),
    .s_ready_o(ready_b), .q_o(q_b), .busy_o(busy_b), .done_o(done_b));
  piso_shifter #(.DATA_WIDTH(2), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_c (
    .clk_i(clk), .s_rst_n_i(rst_n), .enable_i(en_c), .s_data_i(data_c), .s_valid_i(valid_c),
    .s_ready_o(ready_c), .q_o(q_c), .busy_o(busy_c), .done_o(done_c));

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if ({q_a, ready_a, busy_a, done_a} !== 4'b0100) begin
        fails++;
        $display("FAIL reset_a cyc %0d: got q/rdy/busy/done=%b want 0100", i, {q_a, ready_a, busy_a, done_a});
      end
      tests++;
      if ({q_b, ready_b, busy_b, done_b} !== 4'b0100) begin
        fails++;
        $display("FAIL reset_b cyc %0d: got %b want 0100", i, {q_b, ready_b, busy_b, done_b});
      end
      tests++;
      if ({q_c, ready_c, busy_c, done_c} !== 4'b1100) begin
        fails++;
        $display("FAIL reset_c cyc %0d: got %b want 1100", i, {q_c, ready_c, busy_c, done_c});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_msb_first;
    logic [7:0] e = 8'hA5;
    en_a = 1'b1;
    data_a = 8'hA5;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if ({q_a, busy_a, ready_a, done_a} !== {e[7-i], 3'b100}) begin
        fails++;
        $display("FAIL msb_bit%0d: got q/busy/rdy/done=%b want %b", i, {q_a, busy_a, ready_a, done_a}, {e[7-i], 3'b100});
      end
      @(negedge clk);
    end
    tests++;
    if ({q_a, busy_a, ready_a, done_a} !== 4'b0011) begin
      fails++;
      $display("FAIL msb_done: got %b want 0011", {q_a, busy_a, ready_a, done_a});
    end
    @(negedge clk);
    tests++;
    if (done_a !== 1'b0) begin
      fails++;
      $display("FAIL msb_done_pulse: got %b want 0", done_a);
    end
  endtask

  task automatic test_lsb_slow;
    data_b = 8'h01;
    valid_b = 1'b1;
    en_b = 1'b0;
    @(negedge clk);
    valid_b = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      en_b = (k % 3) == 0;
      tests++;
      if ({q_b, busy_b, done_b} !== {k <= 3, 2'b10}) begin
        fails++;
        $display("FAIL lsb_cyc%0d: got q/busy/done=%b want %b", k, {q_b, busy_b, done_b}, {k <= 3, 2'b10});
      end
      @(negedge clk);
    end
    en_b = 1'b0;
    tests++;
    if ({q_b, busy_b, ready_b, done_b} !== 4'b0011) begin
      fails++;
      $display("FAIL lsb_done: got %b want 0011", {q_b, busy_b, ready_b, done_b});
    end
    @(negedge clk);
    tests++;
    if (done_b !== 1'b0) begin
      fails++;
      $display("FAIL lsb_done_pulse: got %b want 0", done_b);
    end
  endtask

  task automatic test_back_to_back;
    en_a = 1'b1;
    data_a = 8'hFF;
    valid_a = 1'b1;
    @(negedge clk);
    data_a = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      tests++;
      if ({q_a, busy_a, done_a} !== 3'b110) begin
        fails++;
        $display("FAIL b2b_w1_cyc%0d: got q/busy/done=%b want 110", i, {q_a, busy_a, done_a});
      end
      @(negedge clk);
    end
    tests++;
    if ({q_a, busy_a, ready_a, done_a} !== 4'b0011) begin
      fails++;
      $display("FAIL b2b_gap: got q/busy/rdy/done=%b want 0011", {q_a, busy_a, ready_a, done_a});
    end
    @(negedge clk);
    valid_a = 1'b0;
    data_a = 8'hFF;
    for (int i = 10; i <= 17; i++) begin
      tests++;
      if ({q_a, busy_a, ready_a, done_a} !== 4'b0100) begin
        fails++;
        $display("FAIL b2b_w2_cyc%0d: got %b want 0100", i, {q_a, busy_a, ready_a, done_a});
      end
      @(negedge clk);
    end
    tests++;
    if ({busy_a, done_a} !== 2'b01) begin
      fails++;
      $display("FAIL b2b_done2: got busy/done=%b want 01", {busy_a, done_a});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [2:0] e = 3'b110;
    en_a = 1'b1;
    data_a = 8'hC3;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({q_a, busy_a} !== {e[2-i], 1'b1}) begin
        fails++;
        $display("FAIL rst_mid_bit%0d: got q/busy=%b want %b", i, {q_a, busy_a}, {e[2-i], 1'b1});
      end
      if (i < 2) @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({q_a, busy_a, ready_a, done_a} !== 4'b0010) begin
      fails++;
      $display("FAIL rst_mid_abort: got %b want 0010", {q_a, busy_a, ready_a, done_a});
    end
    data_a = 8'hFF;
    valid_a = 1'b1;
    @(negedge clk);
    tests++;
    if ({q_a, busy_a, ready_a, done_a} !== 4'b0010) begin
      fails++;
      $display("FAIL rst_priority: got %b want 0010", {q_a, busy_a, ready_a, done_a});
    end
    rst_n = 1'b1;
    valid_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({busy_a, done_a} !== 2'b00) begin
        fails++;
        $display("FAIL rst_no_done%0d: got busy/done=%b want 00", i, {busy_a, done_a});
      end
    end
  endtask

  task automatic test_width2;
    en_c = 1'b1;
    data_c = 2'b01;
    valid_c = 1'b1;
    @(negedge clk);
    valid_c = 1'b0;
    tests++;
    if ({q_c, busy_c, done_c} !== 3'b010) begin
      fails++;
      $display("FAIL w2_bit0: got q/busy/done=%b want 010", {q_c, busy_c, done_c});
    end
    @(negedge clk);
    tests++;
    if ({q_c, busy_c, done_c} !== 3'b110) begin
      fails++;
      $display("FAIL w2_bit1: got %b want 110", {q_c, busy_c, done_c});
    end
    @(negedge clk);
    tests++;
    if ({q_c, busy_c, ready_c, done_c} !== 4'b1011) begin
      fails++;
      $display("FAIL w2_done: got q/busy/rdy/done=%b want 1011", {q_c, busy_c, ready_c, done_c});
    end
    @(negedge clk);
    tests++;
    if ({q_c, busy_c, done_c} !== 3'b100) begin
      fails++;
      $display("FAIL w2_idle: got %b want 100", {q_c, busy_c, done_c});
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_msb_first();
    test_lsb_slow();
    test_back_to_back();
    test_reset_mid();
    test_width2();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
